// File: rtl/reorder_fifo.sv
// reorder_fifo: in-order reorder buffer between dispatch and commit.
// Dispatch pushes one opaque reorder-info entry per accepted instruction.
// Commit sees the oldest entry on a first-word-fall-through output and pops
// it once the instruction retires. A commit abort empties the FIFO in one
// cycle. The entry payload is never interpreted here.
`timescale 1ns/1ps

`ifndef REORDER_INFO_DW
// pc[63:0] + rd0[5+RB-1:0] with RB=1 + six instruction-class flags
`define REORDER_INFO_DW 76
`endif

module reorder_fifo #(
    parameter int DW = `REORDER_INFO_DW,
    parameter int AW = 3
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [DW-1:0] dispatch_info,
    input  logic          reOrder_fifo_push,
    output logic          reOrder_fifo_full,
    output logic [DW-1:0] commit_fifo,
    output logic          reOrder_fifo_empty,
    input  logic          reOrder_fifo_pop,
    input  logic          commit_abort,
    output logic [AW:0]   reOrder_fifo_cnt
);

    localparam int DEPTH = 1 << AW;

    // Payload storage carries no reset; stale data past rd_ptr is never shown.
    logic [DW-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;

    logic push_acc;
    logic pop_acc;

    // Status is derived from current registered pointers only.
    assign reOrder_fifo_empty = (rd_ptr_q == wr_ptr_q);
    assign reOrder_fifo_full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) &&
                                (rd_ptr_q[AW] != wr_ptr_q[AW]);
    assign reOrder_fifo_cnt   = wr_ptr_q - rd_ptr_q;

    // Abort wins over both requests; full/empty gate on current state, so a
    // pop on a full FIFO does not open a slot for a same-cycle push.
    assign push_acc = reOrder_fifo_push && !reOrder_fifo_full  && !commit_abort;
    assign pop_acc  = reOrder_fifo_pop  && !reOrder_fifo_empty && !commit_abort;

    // Head is zeroed while empty so commit never sees a stale entry.
    assign commit_fifo = reOrder_fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values: flush to zero, otherwise advance on accepted requests.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (commit_abort) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset drops every in-flight entry immediately.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry write on an accepted push; contents survive flush and reset.
    always_ff @(posedge CLK) begin
        if (push_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= dispatch_info;
        end
    end

endmodule

// File: tb/tb_reorder_fifo.sv
// Scoreboard bench for reorder_fifo: stimulus queues expected head entries,
// a negedge monitor compares them as commit pops them.
`timescale 1ns/1ps

module tb_reorder_fifo;

    localparam int DW = 76;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic [DW-1:0] dispatch_info;
    logic          reOrder_fifo_push;
    logic          reOrder_fifo_full;
    logic [DW-1:0] commit_fifo;
    logic          reOrder_fifo_empty;
    logic          reOrder_fifo_pop;
    logic          commit_abort;
    logic [AW:0]   reOrder_fifo_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] sb[$];

    reorder_fifo #(.DW(DW), .AW(AW)) dut (
        .CLK               (CLK),
        .RSTn              (RSTn),
        .dispatch_info     (dispatch_info),
        .reOrder_fifo_push (reOrder_fifo_push),
        .reOrder_fifo_full (reOrder_fifo_full),
        .commit_fifo       (commit_fifo),
        .reOrder_fifo_empty(reOrder_fifo_empty),
        .reOrder_fifo_pop  (reOrder_fifo_pop),
        .commit_abort      (commit_abort),
        .reOrder_fifo_cnt  (reOrder_fifo_cnt)
    );

    always #5 CLK = ~CLK;

    // Entry pattern: pc, rd0 derived from pc, flags from pc bits.
    function automatic logic [DW-1:0] mk(input logic [63:0] pc);
        logic [5:0] rd0;
        logic [5:0] flg;
        rd0 = pc[7:2] ^ 6'h2A;
        flg = pc[13:8];
        return {pc, rd0, flg};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic status(input string name, input int cnt, input bit full, input bit empty);
        chk({name, ".cnt"},   128'(reOrder_fifo_cnt),   128'(cnt));
        chk({name, ".full"},  128'(reOrder_fifo_full),  128'(full));
        chk({name, ".empty"}, 128'(reOrder_fifo_empty), 128'(empty));
    endtask

    // One clock: drive at posedge+1, hold through the edge, release after it.
    task automatic cyc(input bit push, input bit pop, input bit abort,
                       input logic [63:0] pc, input bit exp_acc);
        reOrder_fifo_push = push;
        reOrder_fifo_pop  = pop;
        commit_abort      = abort;
        dispatch_info     = mk(pc);
        if (exp_acc) sb.push_back(mk(pc));
        @(posedge CLK);
        #1;
        reOrder_fifo_push = 1'b0;
        reOrder_fifo_pop  = 1'b0;
        commit_abort      = 1'b0;
        dispatch_info     = '0;
    endtask

    // Monitor: every accepted pop must present the oldest queued entry.
    always @(negedge CLK) begin
        if (RSTn === 1'b1) begin
            if (reOrder_fifo_empty) begin
                chk("head_zero_when_empty", 128'(commit_fifo), 128'd0);
            end else if (reOrder_fifo_pop && !commit_abort) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_unexpected: got %0h expected no entry", commit_fifo);
                end else begin
                    chk("pop_order", 128'(commit_fifo), 128'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        RSTn = 1'b0;
        reOrder_fifo_push = 1'b0;
        reOrder_fifo_pop  = 1'b0;
        commit_abort      = 1'b0;
        dispatch_info     = '0;
        #12;
        status("reset", 0, 1'b0, 1'b1);
        chk("reset.head", 128'(commit_fifo), 128'd0);
        #3 RSTn = 1'b1;
        @(posedge CLK);
        #1;

        // Fill 8 entries, cnt tracks each edge.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 64'h1000 + 64'(4 * i), 1);
            chk("fill.cnt", 128'(reOrder_fifo_cnt), 128'(i + 1));
        end
        status("full", 8, 1'b1, 1'b0);
        chk("full.head", 128'(commit_fifo), 128'(mk(64'h1000)));

        // Ninth push is dropped.
        cyc(1, 0, 0, 64'hDEAD, 0);
        status("push_full", 8, 1'b1, 1'b0);

        // Full FIFO with push+pop: pop accepted, push refused.
        cyc(1, 1, 0, 64'hBEEF, 0);
        status("full_pushpop", 7, 1'b0, 1'b0);
        chk("full_pushpop.head", 128'(commit_fifo), 128'(mk(64'h1004)));

        // Drain the remaining 7 (0x1004..0x101C) in order.
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 64'h0, 0);
        status("drained", 0, 1'b0, 1'b1);
        chk("drained.head", 128'(commit_fifo), 128'd0);

        // Pop while empty is ignored.
        cyc(0, 1, 0, 64'h0, 0);
        status("pop_empty", 0, 1'b0, 1'b1);

        // cnt=3, then 20 cycles of push+pop; pointers wrap twice.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 64'h3000 + 64'(4 * i), 1);
        chk("steady.pre", 128'(reOrder_fifo_cnt), 128'd3);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 64'h3000 + 64'(4 * (i + 3)), 1);
            chk("steady.cnt", 128'(reOrder_fifo_cnt), 128'd3);
        end
        chk("steady.head", 128'(commit_fifo), 128'(mk(64'h3000 + 64'(4 * 20))));
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 64'h0, 0);
        status("steady.drained", 0, 1'b0, 1'b1);

        // Flush with cnt=5 plus same-cycle push and pop.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 64'h5000 + 64'(4 * i), 1);
        chk("flush.pre", 128'(reOrder_fifo_cnt), 128'd5);
        cyc(1, 1, 1, 64'h0BAD, 0);
        sb.delete();
        status("flush", 0, 1'b0, 1'b1);
        chk("flush.head", 128'(commit_fifo), 128'd0);
        cyc(1, 0, 0, 64'h2000, 1);
        status("after_flush", 1, 1'b0, 1'b0);
        chk("after_flush.head", 128'(commit_fifo), 128'(mk(64'h2000)));
        cyc(0, 1, 0, 64'h0, 0);
        status("after_flush.pop", 0, 1'b0, 1'b1);

        // Empty: push and pop together, pop refused.
        cyc(1, 1, 0, 64'h4000, 1);
        status("bypass", 1, 1'b0, 1'b0);
        chk("bypass.head", 128'(commit_fifo), 128'(mk(64'h4000)));
        cyc(0, 1, 0, 64'h0, 0);
        status("bypass.pop", 0, 1'b0, 1'b1);

        // Async reset mid-cycle with cnt=6.
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 64'h6000 + 64'(4 * i), 1);
        chk("areset.pre", 128'(reOrder_fifo_cnt), 128'd6);
        #2 RSTn = 1'b0;
        #1;
        sb.delete();
        status("areset", 0, 1'b0, 1'b1);
        chk("areset.head", 128'(commit_fifo), 128'd0);
        @(posedge CLK);
        #3 RSTn = 1'b1;
        @(posedge CLK);
        #1;
        cyc(1, 0, 0, 64'h7000, 1);
        status("post_reset", 1, 1'b0, 1'b0);
        chk("post_reset.head", 128'(commit_fifo), 128'(mk(64'h7000)));
        cyc(0, 1, 0, 64'h0, 0);
        chk("sb_drained", 128'(sb.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reorder_fifo.md
# reorder_fifo

In-order reorder FIFO between dispatch (writer) and the commit stage (reader). Dispatch pushes one reorder-info entry per accepted instruction. Commit sees the oldest entry on a first-word-fall-through output and pops it once the instruction retires. A commit abort (mispredict, trap or xRET) flushes every in-flight entry in one cycle.

## Interface
Parameters:
- DW, `REORDER_INFO_DW`: entry width. Entry layout, MSB first: {pc[63:0], rd0[5+`RB-1:0], isBranch, isSu, isCsr, isEcall, isEbreak, isMret}. The FIFO treats the entry as opaque.
- AW, 3: log2 of depth. DEPTH = 2^AW = 8 entries.

Ports:
- CLK  in  1  core clock; all state updates on the rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- dispatch_info  in  DW  entry to enqueue.
- reOrder_fifo_push  in  1  enqueue request from dispatch.
- reOrder_fifo_full  out  1  no free slot; dispatch must stall.
- commit_fifo  out  DW  oldest entry (head); all zeros while empty.
- reOrder_fifo_empty  out  1  no valid entry.
- reOrder_fifo_pop  in  1  dequeue request from commit.
- commit_abort  in  1  flush all entries.
- reOrder_fifo_cnt  out  AW+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH x DW register array, not reset.
- Pointers: rd_ptr and wr_ptr, each AW+1 bits; the low AW bits index the array and the MSB is the wrap bit.
- Empty: reOrder_fifo_empty = (rd_ptr == wr_ptr).
- Full: reOrder_fifo_full = (low AW bits equal) & (MSBs differ).
- Occupancy: reOrder_fifo_cnt = wr_ptr - rd_ptr, modulo 2^(AW+1).
- Push is accepted iff reOrder_fifo_push & ~reOrder_fifo_full & ~commit_abort.
  - On accept, mem[wr_ptr[AW-1:0]] <= dispatch_info and wr_ptr <= wr_ptr + 1.
- Pop is accepted iff reOrder_fifo_pop & ~reOrder_fifo_empty & ~commit_abort. On accept, rd_ptr <= rd_ptr + 1.
- Push and pop may both be accepted in one cycle.
  - When full, a pop frees no slot in that cycle. The push is still refused because full is evaluated on current state.
  - When empty, a pop is refused. The pushed entry becomes visible on commit_fifo the next cycle.
- Flush: commit_abort = 1 sets rd_ptr <= 0 and wr_ptr <= 0 on the next edge.
  - A same-cycle push or pop is discarded.
  - The array contents are left stale.
- Ignored requests: push while full and pop while empty are silently ignored. No error flag, no state change.
- Output: commit_fifo = reOrder_fifo_empty ? 0 : mem[rd_ptr[AW-1:0]]. This is combinational from registered state; no input-to-output path.
- Pointer wrap: pointers wrap naturally modulo 2^(AW+1). Index DEPTH-1 is followed by index 0 with the MSB toggled.

## Timing
- Reset (RSTn low, asynchronous): rd_ptr = wr_ptr = 0, so reOrder_fifo_empty = 1, reOrder_fifo_full = 0, reOrder_fifo_cnt = 0, commit_fifo = 0.
- Reset release takes effect at the next CLK edge with no extra delay cycle.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Push-to-visible latency: 1 cycle. An entry pushed at edge N into an empty FIFO appears on commit_fifo after edge N, with empty deasserting at the same time.
- Pop-to-next latency: 1 cycle. After a pop at edge N, the next entry, or zeros when now empty, appears after edge N.
- full, empty and cnt all update together after the accepting edge.
- commit_abort is sampled on the edge. After that edge the FIFO is empty, and dispatch may push in the following cycle.
- Throughput: 1 push and 1 pop per cycle sustained, with no bubbles.

## Test plan
- Reset and fill:
  - Reset, then check empty=1, full=0, cnt=0, commit_fifo=0.
  - Push 8 entries with pc = 0x1000, 0x1004, ... -> after the 8th edge full=1 and cnt=8.
  - A 9th push is ignored: cnt stays 8 and the entries are unchanged.
- Drain order: from full, pop 8 times -> commit_fifo pc reads 0x1000 through 0x101C in order; after the last pop empty=1 and commit_fifo=0.
- Concurrent push/pop:
  - With cnt=3, push and pop every cycle for 20 cycles -> cnt stays 3, output order matches input order, and the pointers wrap at least twice.
  - Pop while empty and push while full -> no state change.
- Flush:
  - With cnt=5, assert commit_abort together with push and pop -> next cycle empty=1 and cnt=0; the same-cycle push is not stored.
  - Push 0x2000 the following cycle -> commit_fifo pc = 0x2000.
- Empty bypass edge: on an empty FIFO, push and pop in the same cycle -> the pop is refused and cnt=1 next cycle with the pushed entry at the head.
- Async reset: assert RSTn=0 mid-cycle with cnt=6 -> empty=1, cnt=0 and commit_fifo=0 before the next CLK edge.
